// File: rtl/rx_readout_if.sv
// Sample input, burst command, host FIFO write port and overflow status of rx_readout.
// The bench takes the master side; the readout block takes the slave side.
interface rx_readout_if #(
  parameter int AW = 10
);
  logic          in_valid;
  logic [23:0]   in_i;
  logic [23:0]   in_q;
  logic          cmd_start;
  logic [15:0]   cmd_count;
  logic          hb_orst;
  logic          rx_rd;
  logic [15:0]   rx_dout;
  logic          busy;
  logic [AW:0]   fill;
  logic          hb_ovfl;

  modport master (
    output in_valid, in_i, in_q, cmd_start, cmd_count, hb_orst,
    input  rx_rd, rx_dout, busy, fill, hb_ovfl
  );

  modport slave (
    input  in_valid, in_i, in_q, cmd_start, cmd_count, hb_orst,
    output rx_rd, rx_dout, busy, fill, hb_ovfl
  );
endinterface

// File: rtl/rx_readout.sv
// Circular I/Q sample buffer drained in bursts of 16-bit words: 1 fetch bubble, then 3 words/sample.
// No backpressure: burst length is clamped to fit the host FIFO; samples arriving when full are dropped.
module rx_readout #(
  parameter int AW       = 10,
  parameter int SPIBUF_W = 2048,
  parameter int WPS      = 3
) (
  input  logic        hb_clk,
  input  logic        rst,
  rx_readout_if.slave bus
);
  localparam int          DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);
  localparam logic [15:0] MAX_N = 16'(SPIBUF_W / WPS);

  typedef struct packed {
    logic [23:0] i;
    logic [23:0] q;
  } sample_t;

  typedef enum logic [2:0] {IDLE, FETCH, W0, W1, W2} state_t;

  sample_t       mem [DEPTH];
  sample_t       rd_sample;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   fill_q;
  state_t        state;
  logic [15:0]   rem;
  logic [31:0]   hold;
  logic          ovfl_q;
  logic          rd_q;
  logic [15:0]   dout_q;
  logic          busy_q;

  logic          wr_acc;
  logic          drop;
  logic          pop;
  logic [15:0]   n_req;

  always_comb begin
    wr_acc    = bus.in_valid && (fill_q < FULL);
    drop      = bus.in_valid && (fill_q == FULL);
    pop       = (state == FETCH) || ((state == W2) && (rem > 16'd1));
    rd_sample = mem[rp];
    n_req     = bus.cmd_count;
    if (16'(fill_q) < n_req) n_req = 16'(fill_q);
    if (MAX_N < n_req)       n_req = MAX_N;
  end

  // Storage has no reset; after reset the contents are unreachable because fill is 0.
  always_ff @(posedge hb_clk) begin
    if (wr_acc) mem[wp] <= sample_t'({bus.in_i, bus.in_q});
  end

  always_ff @(posedge hb_clk or posedge rst) begin
    if (rst) begin
      wp     <= '0;
      rp     <= '0;
      fill_q <= '0;
      state  <= IDLE;
      rem    <= '0;
      hold   <= '0;
      ovfl_q <= 1'b0;
      rd_q   <= 1'b0;
      dout_q <= '0;
      busy_q <= 1'b0;
    end else begin
      if (wr_acc) wp <= wp + 1'b1;
      if (pop)    rp <= rp + 1'b1;
      fill_q <= fill_q + (AW + 1)'(wr_acc) - (AW + 1)'(pop);

      if (drop)             ovfl_q <= 1'b1;
      else if (bus.hb_orst) ovfl_q <= 1'b0;

      case (state)
        IDLE: begin
          rd_q <= 1'b0;
          if (bus.cmd_start && (n_req != 16'd0)) begin
            rem    <= n_req;
            busy_q <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: state <= W0;
        W0: begin
          dout_q <= hold[31:16];
          state  <= W1;
        end
        W1: begin
          dout_q <= hold[15:0];
          state  <= W2;
        end
        W2: begin
          if (rem > 16'd1) begin
            rem   <= rem - 16'd1;
            state <= W0;
          end else begin
            rem    <= '0;
            rd_q   <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // The popped sample's first word goes straight out; the other two wait in hold.
      if (pop) begin
        dout_q <= rd_sample.i[23:8];
        hold   <= {rd_sample.q[23:8], rd_sample.i[7:0], rd_sample.q[7:0]};
        rd_q   <= 1'b1;
      end
    end
  end

  assign bus.rx_rd   = rd_q;
  assign bus.rx_dout = dout_q;
  assign bus.busy    = busy_q;
  assign bus.fill    = fill_q;
  assign bus.hb_ovfl = ovfl_q;
endmodule

// File: tb/tb_rx_readout.sv
// Directed bench for rx_readout: a queue-based model predicts words, busy window, fill and overflow.
module tb_rx_readout;
  logic hb_clk;
  logic rst;
  rx_readout_if #(.AW(10)) bus();

  rx_readout #(.AW(10), .SPIBUF_W(2048), .WPS(3)) dut (
    .hb_clk (hb_clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial begin
    hb_clk = 1'b0;
    forever #5 hb_clk = ~hb_clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: sample queue, expected word queue, remaining busy cycles of the current burst.
  logic [47:0] mq[$];
  logic [15:0] ewq[$];
  int          m_cyc;
  int          m_n3;
  logic        m_ovfl;

  always @(posedge hb_clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      ewq.delete();
      m_cyc  = 0;
      m_n3   = 0;
      m_ovfl = 1'b0;
    end else begin
      int   n;
      bit   idle;
      logic drp;
      logic [47:0] s;
      idle = (m_cyc == 0);
      if (m_cyc > 0) m_cyc--;
      if (bus.cmd_start && idle) begin
        n = int'(bus.cmd_count);
        if (mq.size() < n) n = mq.size();
        if (n > 2048 / 3)  n = 2048 / 3;
        if (n > 0) begin
          for (int k = 0; k < n; k++) begin
            s = mq.pop_front();
            ewq.push_back(s[47:32]);
            ewq.push_back(s[23:8]);
            ewq.push_back({s[31:24], s[7:0]});
          end
          m_n3  = 3 * n;
          m_cyc = 3 * n + 1;
        end
      end
      drp = 1'b0;
      if (bus.in_valid) begin
        if (mq.size() < 1024) mq.push_back({bus.in_i, bus.in_q});
        else drp = 1'b1;
      end
      if (drp) m_ovfl = 1'b1;
      else if (bus.hb_orst) m_ovfl = 1'b0;
    end
  end

  logic [15:0] got[$];
  int          rd_cnt = 0;

  always @(negedge hb_clk) begin
    bit exp_rd;
    exp_rd = (m_cyc > 0) && (m_cyc <= m_n3);
    chk("busy", bus.busy, m_cyc > 0);
    chk("rx_rd", bus.rx_rd, exp_rd);
    if (exp_rd) begin
      if (ewq.size() == 0) chk("word_available", 0, 1);
      else chk("rx_dout", bus.rx_dout, ewq.pop_front());
    end
    if (bus.rx_rd) begin
      got.push_back(bus.rx_dout);
      rd_cnt++;
    end
    chk("hb_ovfl", bus.hb_ovfl, m_ovfl);
    if (m_cyc == 0) chk("fill", bus.fill, mq.size());
  end

  int seq = 0;

  task automatic push(input logic [23:0] i, input logic [23:0] q);
    bus.in_valid = 1'b1;
    bus.in_i     = i;
    bus.in_q     = q;
    @(negedge hb_clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic push_n(input int n);
    for (int k = 0; k < n; k++) begin
      push(24'(seq * 7 + 1), 24'(seq * 13) ^ 24'h5A5A5A);
      seq++;
    end
  endtask

  task automatic cmd(input logic [15:0] n);
    bus.cmd_start = 1'b1;
    bus.cmd_count = n;
    @(negedge hb_clk);
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      if (!bus.busy) done = 1'b1;
      else @(negedge hb_clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy still 1 after %0d cycles", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    bus.in_valid  = 1'b0;
    bus.in_i      = '0;
    bus.in_q      = '0;
    bus.cmd_start = 1'b0;
    bus.cmd_count = '0;
    bus.hb_orst   = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge hb_clk);
    chk("rst_rx_rd", bus.rx_rd, 0);
    chk("rst_dout", bus.rx_dout, 0);
    chk("rst_fill", bus.fill, 0);
    rst = 1'b0;
    @(negedge hb_clk);

    // Basic 2-sample burst with exact cycle timing.
    push(24'h123456, 24'hABCDEF);
    push(24'h123457, 24'hABCDEE);
    push(24'h123458, 24'hABCDED);
    push(24'h123459, 24'hABCDEC);
    chk("fill_4", bus.fill, 4);
    b = got.size();
    cmd(16'd2);
    chk("fetch_bubble_rd", bus.rx_rd, 0);
    chk("fetch_busy", bus.busy, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge hb_clk);
      chk("burst_rd_run", bus.rx_rd, 1);
    end
    @(negedge hb_clk);
    chk("busy_drop", bus.busy, 0);
    chk("w0", got[b],     16'h1234);
    chk("w1", got[b + 1], 16'hABCD);
    chk("w2", got[b + 2], 16'h56EF);
    chk("w3", got[b + 3], 16'h1234);
    chk("w4", got[b + 4], 16'hABCD);
    chk("w5", got[b + 5], 16'h57EE);
    chk("fill_2", bus.fill, 2);

    // Count larger than fill.
    push_n(3);
    b = rd_cnt;
    cmd(16'd100);
    wait_idle(100);
    chk("clamp_fill_words", rd_cnt - b, 15);
    chk("clamp_fill_empty", bus.fill, 0);

    // Zero-length requests.
    cmd(16'd5);
    @(negedge hb_clk);
    chk("empty_cmd_busy", bus.busy, 0);
    push_n(2);
    b = rd_cnt;
    cmd(16'd0);
    @(negedge hb_clk);
    chk("zero_cmd_busy", bus.busy, 0);
    chk("zero_cmd_words", rd_cnt - b, 0);

    // Fill to capacity, overflow and clear.
    push_n(1022);
    chk("fill_full", bus.fill, 1024);
    push_n(1);
    chk("ovfl_set", bus.hb_ovfl, 1);
    chk("ovfl_fill", bus.fill, 1024);
    bus.hb_orst = 1'b1;
    @(negedge hb_clk);
    bus.hb_orst = 1'b0;
    chk("ovfl_clear", bus.hb_ovfl, 0);
    bus.hb_orst = 1'b1;
    push_n(1);
    bus.hb_orst = 1'b0;
    chk("ovfl_set_wins", bus.hb_ovfl, 1);

    // Host FIFO clamp and ignored mid-burst command.
    b = rd_cnt;
    cmd(16'hFFFF);
    repeat (100) @(negedge hb_clk);
    cmd(16'd5);
    wait_idle(3000);
    chk("max_burst_words", rd_cnt - b, 2046);
    chk("max_burst_fill", bus.fill, 342);
    cmd(16'hFFFF);
    wait_idle(2000);
    chk("drain_fill", bus.fill, 0);

    // Writes on every cycle of a 3-sample burst.
    push_n(5);
    for (int k = 0; k < 9; k++) begin
      bus.cmd_start = (k == 0);
      bus.cmd_count = 16'd3;
      bus.in_valid  = 1'b1;
      bus.in_i      = 24'(seq * 7 + 1);
      bus.in_q      = 24'(seq * 13) ^ 24'h5A5A5A;
      seq++;
      @(negedge hb_clk);
    end
    bus.cmd_start = 1'b0;
    bus.in_valid  = 1'b0;
    wait_idle(50);
    chk("concurrent_fill", bus.fill, 11);
    cmd(16'hFFFF);
    wait_idle(100);

    // Asynchronous reset in the middle of a burst.
    push_n(3);
    cmd(16'd3);
    @(negedge hb_clk);
    @(negedge hb_clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_rx_rd", bus.rx_rd, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_fill", bus.fill, 0);
    chk("arst_ovfl", bus.hb_ovfl, 0);
    @(negedge hb_clk);
    rst = 1'b0;
    @(negedge hb_clk);
    push_n(1);
    b = rd_cnt;
    cmd(16'd1);
    wait_idle(20);
    chk("post_rst_words", rd_cnt - b, 3);
    repeat (2) @(negedge hb_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
